// File: rtl/rf_arbiter_if.sv
// rf_arbiter_if
// Groups the two requester command/response channels and the register-file
// access port of rf_arbiter into one bundle.
//   Requester N (N = 0, 1):
//     ReqN / WeN / AddrN / WDataN : command, held by the requester until AckN
//     AckN                        : one-cycle completion pulse
//     RValidN                     : one-cycle pulse with AckN on reads only
//     RDataN                      : last read result for requester N
//   Register file:
//     RF_WrEn / RF_RdEn           : access strobes (never both high)
//     RF_Address / RF_WrData      : access address and write data
//     RF_RdData                   : read data, valid the cycle after RF_RdEn
//   Busy                          : arbiter is in the middle of a command
// Modports: master = requesters + register file side, slave = the arbiter.
interface rf_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  Req0;
    logic                  We0;
    logic [ADDR_WIDTH-1:0] Addr0;
    logic [DATA_WIDTH-1:0] WData0;
    logic                  Ack0;
    logic                  RValid0;
    logic [DATA_WIDTH-1:0] RData0;

    logic                  Req1;
    logic                  We1;
    logic [ADDR_WIDTH-1:0] Addr1;
    logic [DATA_WIDTH-1:0] WData1;
    logic                  Ack1;
    logic                  RValid1;
    logic [DATA_WIDTH-1:0] RData1;

    logic                  RF_WrEn;
    logic                  RF_RdEn;
    logic [ADDR_WIDTH-1:0] RF_Address;
    logic [DATA_WIDTH-1:0] RF_WrData;
    logic [DATA_WIDTH-1:0] RF_RdData;

    logic                  Busy;

    modport master (
        output Req0, We0, Addr0, WData0,
        output Req1, We1, Addr1, WData1,
        output RF_RdData,
        input  Ack0, RValid0, RData0,
        input  Ack1, RValid1, RData1,
        input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
        input  Busy
    );

    modport slave (
        input  Req0, We0, Addr0, WData0,
        input  Req1, We1, Addr1, WData1,
        input  RF_RdData,
        output Ack0, RValid0, RData0,
        output Ack1, RValid1, RData1,
        output RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
        output Busy
    );
endinterface

// File: rtl/rf_arbiter.sv
// rf_arbiter
// Round-robin arbiter that shares one single-port register file between two
// requesters. Each accepted command is a single-beat read or write; writes
// complete in one cycle, reads take a READ cycle plus a CAPTURE cycle to pick
// up the registered read data, which is then returned to the issuing side.
// Ports:
//   CLK : rising-edge clock
//   RST : synchronous active-high reset
//   bus : rf_arbiter_if.slave (requester channels, register-file port, Busy)
module rf_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic        CLK,
    input  logic        RST,
    rf_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        READ    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  last_gnt_q, last_gnt_d;
    // Owner of the in-flight command. Its direction is carried by the
    // WRITE/READ state itself, so no separate We register is kept.
    logic                  cmd_id_q, cmd_id_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic                  elig0;
    logic                  elig1;
    logic                  grant;
    logic                  win;
    logic                  win_we;

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        cmd_id_d    = cmd_id_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        grant       = 1'b0;
        win         = 1'b0;
        win_we      = 1'b0;

        // A request still held during its own ack cycle is already served.
        elig0 = bus.Req0 & ~ack0_q;
        elig1 = bus.Req1 & ~ack1_q;

        case (state_q)
            IDLE: begin
                if (elig0 && elig1) begin
                    grant = 1'b1;
                    win   = ~last_gnt_q;
                end else if (elig0) begin
                    grant = 1'b1;
                    win   = 1'b0;
                end else if (elig1) begin
                    grant = 1'b1;
                    win   = 1'b1;
                end

                if (grant) begin
                    win_we      = win ? bus.We1 : bus.We0;
                    last_gnt_d  = win;
                    cmd_id_d    = win;
                    cmd_addr_d  = win ? bus.Addr1 : bus.Addr0;
                    cmd_wdata_d = win ? bus.WData1 : bus.WData0;
                    if (win_we) begin
                        // Registered here so Ack is high during the WRITE cycle.
                        state_d = WRITE;
                        ack0_d  = ~win;
                        ack1_d  = win;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d = IDLE;
                if (cmd_id_q) begin
                    rdata1_d  = bus.RF_RdData;
                    ack1_d    = 1'b1;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = bus.RF_RdData;
                    ack0_d    = 1'b1;
                    rvalid0_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;   // first tie after reset goes to requester 0
            cmd_id_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            cmd_id_q    <= cmd_id_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign bus.Ack0    = ack0_q;
    assign bus.Ack1    = ack1_q;
    assign bus.RValid0 = rvalid0_q;
    assign bus.RValid1 = rvalid1_q;
    assign bus.RData0  = rdata0_q;
    assign bus.RData1  = rdata1_q;

    // Strobes are masked by RST so no access lands in a reset cycle, even
    // when reset arrives in the middle of a WRITE or READ.
    assign bus.RF_WrEn    = (state_q == WRITE) & ~RST;
    assign bus.RF_RdEn    = (state_q == READ) & ~RST;
    // Address/data come straight from the command registers, which are only
    // loaded on a grant, so they hold their last values while unused.
    assign bus.RF_Address = cmd_addr_q;
    assign bus.RF_WrData  = cmd_wdata_q;
    assign bus.Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rf_arbiter.sv
// tb_rf_arbiter
// Directed bench for rf_arbiter with a behavioural 8x16 register file that
// has a one-cycle registered read. Each scenario is a task with inline checks.
module tb_rf_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    rf_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus();

    rf_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    logic [15:0] mem [8];
    logic [15:0] rd_q;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8; i++) mem[i] <= 16'h1000 + 16'(i);
            rd_q <= 16'h0;
        end else begin
            if (bus.RF_WrEn) mem[bus.RF_Address] <= bus.RF_WrData;
            if (bus.RF_RdEn) rd_q <= mem[bus.RF_Address];
        end
    end

    assign bus.RF_RdData = rd_q;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_init = 1'b1;
        bus.Req0 = 1'b1; bus.We0 = 1'b0; bus.Addr0 = 3'd3; bus.WData0 = 16'h0;
        bus.Req1 = 1'b1; bus.We1 = 1'b0; bus.Addr1 = 3'd4; bus.WData1 = 16'h0;
        for (int c = 0; c < 2; c++) begin
            step();
            mem_init = 1'b0;
            vectors++; if (bus.RF_WrEn !== 1'b0) begin miscompares++; $display("FAIL rst_wren cyc%0d got=%b exp=0", c, bus.RF_WrEn); end
            vectors++; if (bus.RF_RdEn !== 1'b0) begin miscompares++; $display("FAIL rst_rden cyc%0d got=%b exp=0", c, bus.RF_RdEn); end
            vectors++; if (bus.Ack0 !== 1'b0) begin miscompares++; $display("FAIL rst_ack0 cyc%0d got=%b exp=0", c, bus.Ack0); end
            vectors++; if (bus.Ack1 !== 1'b0) begin miscompares++; $display("FAIL rst_ack1 cyc%0d got=%b exp=0", c, bus.Ack1); end
            vectors++; if (bus.RData0 !== 16'h0) begin miscompares++; $display("FAIL rst_rdata0 cyc%0d got=%h exp=0000", c, bus.RData0); end
            vectors++; if (bus.RData1 !== 16'h0) begin miscompares++; $display("FAIL rst_rdata1 cyc%0d got=%h exp=0000", c, bus.RData1); end
            vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy cyc%0d got=%b exp=0", c, bus.Busy); end
        end
        rst = 1'b0;
        step();   // tie resolved: requester 0 wins, READ
        vectors++; if (bus.RF_RdEn !== 1'b1) begin miscompares++; $display("FAIL first_gnt_rden got=%b exp=1", bus.RF_RdEn); end
        vectors++; if (bus.RF_Address !== 3'd3) begin miscompares++; $display("FAIL first_gnt_addr got=%0d exp=3", bus.RF_Address); end
        vectors++; if (bus.Busy !== 1'b1) begin miscompares++; $display("FAIL first_gnt_busy got=%b exp=1", bus.Busy); end
        step();   // CAPTURE
        step();   // IDLE, ack to requester 0
        vectors++; if (bus.Ack0 !== 1'b1) begin miscompares++; $display("FAIL first_ack0 got=%b exp=1", bus.Ack0); end
        vectors++; if (bus.Ack1 !== 1'b0) begin miscompares++; $display("FAIL first_ack1 got=%b exp=0", bus.Ack1); end
        vectors++; if (bus.RData0 !== 16'h1003) begin miscompares++; $display("FAIL first_rdata0 got=%h exp=1003", bus.RData0); end
        bus.Req0 = 1'b0;
        step();   // requester 1 READ
        vectors++; if (bus.RF_Address !== 3'd4) begin miscompares++; $display("FAIL second_gnt_addr got=%0d exp=4", bus.RF_Address); end
        step();
        step();
        vectors++; if (bus.Ack1 !== 1'b1) begin miscompares++; $display("FAIL second_ack1 got=%b exp=1", bus.Ack1); end
        vectors++; if (bus.RData1 !== 16'h1004) begin miscompares++; $display("FAIL second_rdata1 got=%h exp=1004", bus.RData1); end
        bus.Req1 = 1'b0;
        step();
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL reset_end_busy got=%b exp=0", bus.Busy); end
    endtask

    task automatic test_contention();
        bus.Req0 = 1'b1; bus.We0 = 1'b1; bus.Addr0 = 3'd5; bus.WData0 = 16'h0194;
        bus.Req1 = 1'b1; bus.We1 = 1'b0; bus.Addr1 = 3'd5;
        step();   // WRITE for requester 0
        vectors++; if (bus.Ack0 !== 1'b1) begin miscompares++; $display("FAIL cont_ack0 got=%b exp=1", bus.Ack0); end
        vectors++; if (bus.Ack1 !== 1'b0) begin miscompares++; $display("FAIL cont_ack1_early got=%b exp=0", bus.Ack1); end
        vectors++; if (bus.RF_WrEn !== 1'b1) begin miscompares++; $display("FAIL cont_wren got=%b exp=1", bus.RF_WrEn); end
        vectors++; if (bus.RF_WrData !== 16'h0194) begin miscompares++; $display("FAIL cont_wrdata got=%h exp=0194", bus.RF_WrData); end
        bus.Req0 = 1'b0;
        step();   // IDLE
        step();   // READ for requester 1
        vectors++; if (bus.RF_RdEn !== 1'b1) begin miscompares++; $display("FAIL cont_rden got=%b exp=1", bus.RF_RdEn); end
        vectors++; if (bus.RF_WrEn !== 1'b0) begin miscompares++; $display("FAIL cont_wren_off got=%b exp=0", bus.RF_WrEn); end
        step();   // CAPTURE
        step();
        vectors++; if (bus.Ack1 !== 1'b1) begin miscompares++; $display("FAIL cont_ack1 got=%b exp=1", bus.Ack1); end
        vectors++; if (bus.RValid1 !== 1'b1) begin miscompares++; $display("FAIL cont_rvalid1 got=%b exp=1", bus.RValid1); end
        vectors++; if (bus.RData1 !== 16'h0194) begin miscompares++; $display("FAIL cont_rdata1 got=%h exp=0194", bus.RData1); end
        bus.Req1 = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        int acks = 0;
        int rden = 0;
        logic exp_side;
        bus.Req0 = 1'b1; bus.We0 = 1'b0; bus.Addr0 = 3'd1;
        bus.Req1 = 1'b1; bus.We1 = 1'b0; bus.Addr1 = 3'd6;
        for (int cyc = 0; cyc < 40 && acks < 8; cyc++) begin
            step();
            if (bus.RF_RdEn) rden++;
            vectors++; if ((bus.Ack0 & bus.Ack1) !== 1'b0) begin miscompares++; $display("FAIL rr_double_ack cyc%0d got=%b%b exp=not both", cyc, bus.Ack0, bus.Ack1); end
            if (bus.Ack0 || bus.Ack1) begin
                exp_side = acks[0];
                vectors++; if (bus.Ack1 !== exp_side) begin miscompares++; $display("FAIL rr_order ack%0d got=req%0d exp=req%0d", acks, bus.Ack1, exp_side); end
                if (bus.Ack1) begin
                    vectors++; if (bus.RData1 !== 16'h1006) begin miscompares++; $display("FAIL rr_rdata1 ack%0d got=%h exp=1006", acks, bus.RData1); end
                end else begin
                    vectors++; if (bus.RData0 !== 16'h1001) begin miscompares++; $display("FAIL rr_rdata0 ack%0d got=%h exp=1001", acks, bus.RData0); end
                end
                acks++;
                if (acks == 8) begin bus.Req0 = 1'b0; bus.Req1 = 1'b0; end
            end
        end
        bus.Req0 = 1'b0; bus.Req1 = 1'b0;
        vectors++; if (acks !== 8) begin miscompares++; $display("FAIL rr_ack_count got=%0d exp=8", acks); end
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus.RF_RdEn) rden++;
        end
        vectors++; if (rden !== 8) begin miscompares++; $display("FAIL rr_rf_reads got=%0d exp=8", rden); end
    endtask

    task automatic test_write_read();
        bus.Req0 = 1'b1; bus.We0 = 1'b1; bus.Addr0 = 3'd2; bus.WData0 = 16'h0025;
        step();   // WRITE
        vectors++; if (bus.Ack0 !== 1'b1) begin miscompares++; $display("FAIL wr_ack0 got=%b exp=1", bus.Ack0); end
        vectors++; if (bus.RF_WrEn !== 1'b1) begin miscompares++; $display("FAIL wr_wren got=%b exp=1", bus.RF_WrEn); end
        vectors++; if (bus.RF_Address !== 3'd2) begin miscompares++; $display("FAIL wr_addr got=%0d exp=2", bus.RF_Address); end
        vectors++; if (bus.RValid0 !== 1'b0) begin miscompares++; $display("FAIL wr_rvalid0 got=%b exp=0", bus.RValid0); end
        bus.We0 = 1'b0;   // new read command presented at the edge ending Ack
        step();   // IDLE
        vectors++; if (bus.Ack0 !== 1'b0) begin miscompares++; $display("FAIL rd_idle_ack0 got=%b exp=0", bus.Ack0); end
        step();   // READ
        vectors++; if (bus.RF_RdEn !== 1'b1) begin miscompares++; $display("FAIL rd_rden got=%b exp=1", bus.RF_RdEn); end
        vectors++; if (bus.RF_Address !== 3'd2) begin miscompares++; $display("FAIL rd_addr got=%0d exp=2", bus.RF_Address); end
        step();   // CAPTURE
        vectors++; if (bus.Ack0 !== 1'b0) begin miscompares++; $display("FAIL rd_capture_ack0 got=%b exp=0", bus.Ack0); end
        step();
        vectors++; if (bus.Ack0 !== 1'b1) begin miscompares++; $display("FAIL rd_ack0 got=%b exp=1", bus.Ack0); end
        vectors++; if (bus.RValid0 !== 1'b1) begin miscompares++; $display("FAIL rd_rvalid0 got=%b exp=1", bus.RValid0); end
        vectors++; if (bus.RData0 !== 16'h0025) begin miscompares++; $display("FAIL rd_rdata0 got=%h exp=0025", bus.RData0); end
        bus.Req0 = 1'b0;
        step();
        vectors++; if (bus.RValid0 !== 1'b0) begin miscompares++; $display("FAIL rd_rvalid0_pulse got=%b exp=0", bus.RValid0); end
        vectors++; if (bus.RData0 !== 16'h0025) begin miscompares++; $display("FAIL rd_rdata0_hold got=%h exp=0025", bus.RData0); end
    endtask

    task automatic test_reset_mid_read();
        bus.Req1 = 1'b1; bus.We1 = 1'b0; bus.Addr1 = 3'd6;
        step();   // READ
        vectors++; if (bus.RF_RdEn !== 1'b1) begin miscompares++; $display("FAIL mid_rden got=%b exp=1", bus.RF_RdEn); end
        step();   // CAPTURE
        rst = 1'b1;
        #1;
        vectors++; if (bus.RF_RdEn !== 1'b0) begin miscompares++; $display("FAIL mid_rst_rden got=%b exp=0", bus.RF_RdEn); end
        step();
        vectors++; if (bus.Ack1 !== 1'b0) begin miscompares++; $display("FAIL mid_ack1 got=%b exp=0", bus.Ack1); end
        vectors++; if (bus.RValid1 !== 1'b0) begin miscompares++; $display("FAIL mid_rvalid1 got=%b exp=0", bus.RValid1); end
        vectors++; if (bus.RData1 !== 16'h0) begin miscompares++; $display("FAIL mid_rdata1 got=%h exp=0000", bus.RData1); end
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy got=%b exp=0", bus.Busy); end
        vectors++; if (bus.RF_RdEn !== 1'b0) begin miscompares++; $display("FAIL mid_rst_rden2 got=%b exp=0", bus.RF_RdEn); end
        bus.Req1 = 1'b0;
        rst = 1'b0;
        step();
        // Reset landing in a WRITE cycle must suppress the register-file write.
        bus.Req0 = 1'b1; bus.We0 = 1'b1; bus.Addr0 = 3'd7; bus.WData0 = 16'hBEEF;
        step();   // WRITE
        vectors++; if (bus.RF_WrEn !== 1'b1) begin miscompares++; $display("FAIL wrst_wren_pre got=%b exp=1", bus.RF_WrEn); end
        rst = 1'b1;
        #1;
        vectors++; if (bus.RF_WrEn !== 1'b0) begin miscompares++; $display("FAIL wrst_wren_gated got=%b exp=0", bus.RF_WrEn); end
        step();
        vectors++; if (mem[7] !== 16'h1007) begin miscompares++; $display("FAIL wrst_mem7 got=%h exp=1007", mem[7]); end
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL wrst_busy got=%b exp=0", bus.Busy); end
        bus.Req0 = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_held_masking();
        int rden = 0;
        int acks = 0;
        int ack_step = -1;
        bus.Req0 = 1'b1; bus.We0 = 1'b0; bus.Addr0 = 3'd2;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.RF_RdEn) rden++;
            if (bus.Ack0) begin
                acks++;
                if (ack_step < 0) ack_step = k;
                vectors++; if (bus.RData0 !== 16'h0025) begin miscompares++; $display("FAIL held_rdata0 got=%h exp=0025", bus.RData0); end
            end
            // Req0 stays high through the edge that closes the ack cycle.
            if (ack_step >= 0 && k == ack_step + 1) bus.Req0 = 1'b0;
        end
        bus.Req0 = 1'b0;
        vectors++; if (ack_step !== 2) begin miscompares++; $display("FAIL held_ack_latency got=%0d exp=2", ack_step); end
        vectors++; if (rden !== 1) begin miscompares++; $display("FAIL held_rf_reads got=%0d exp=1", rden); end
        vectors++; if (acks !== 1) begin miscompares++; $display("FAIL held_ack_count got=%0d exp=1", acks); end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_round_robin();
        test_write_read();
        test_reset_mid_read();
        test_held_masking();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rf_arbiter.md
Name: rf_arbiter

Overview:
- Round-robin arbiter sharing one 8x16 single-port register file between two requesters, e.g. a CPU-side port and a DMA/config port.
- Serialises single-beat read and write commands and drives the register file's WrEn/RdEn/Address/WrData.
- Captures RdData (1-cycle registered read latency) and returns it to the requester that issued the read.

Parameters:
- DATA_WIDTH, 16, register data width
- ADDR_WIDTH, 3, register address width (2^ADDR_WIDTH registers)

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous reset, active-high
- Req0  in  1  requester 0 command valid; held until Ack0
- We0  in  1  requester 0: 1=write, 0=read
- Addr0  in  ADDR_WIDTH  requester 0 address
- WData0  in  DATA_WIDTH  requester 0 write data
- Ack0  out  1  one-cycle pulse: requester 0 command completed
- RValid0  out  1  one-cycle pulse with Ack0 on reads only
- RData0  out  DATA_WIDTH  requester 0 read data; holds until next requester-0 read completes
- Req1, We1, Addr1, WData1, Ack1, RValid1, RData1: same as requester 0, for requester 1
- RF_WrEn  out  1  register file write enable
- RF_RdEn  out  1  register file read enable
- RF_Address  out  ADDR_WIDTH  register file address
- RF_WrData  out  DATA_WIDTH  register file write data
- RF_RdData  in  DATA_WIDTH  register file read data, valid the cycle after RF_RdEn
- Busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking/reset: one clock CLK; RST synchronous, active-high.
- RST=1 at a rising edge forces state=IDLE, LastGnt=1, and clears Ack*, RValid*, RData*, command registers, and RF_Address/RF_WrData to 0.
- RF_WrEn and RF_RdEn are gated combinationally by ~RST: no register-file access occurs in any cycle RST=1.
- FSM states: IDLE, WRITE, READ, CAPTURE.
- IDLE: the eligible set is {N : ReqN=1 and AckN=0}. Masking by AckN prevents double service of a request still held during its ack cycle.
  - Empty set: stay in IDLE.
  - One eligible requester: it wins.
  - Both eligible: the requester != LastGnt wins.
  - On a win: latch the winner's We/Addr/WData into command registers, set LastGnt=winner, go to WRITE if We=1, else READ.
- WRITE (1 cycle): RF_WrEn=1, RF_Address/RF_WrData from command registers; AckN=1 for the winner in this cycle; next state IDLE. Write latency: Ack one cycle after the request is sampled.
- READ (1 cycle): RF_RdEn=1, RF_Address from command register; next state CAPTURE.
- CAPTURE (1 cycle): RF_RdData is valid. At the closing edge: RDataN <= RF_RdData; AckN and RValidN are registered high for the next cycle (IDLE); next state IDLE. Read latency: Ack/RValid three cycles after the request is sampled.
- RF_WrEn and RF_RdEn are never both high. Both are 0 in IDLE and CAPTURE. RF_Address/RF_WrData hold their last values when unused.
- Ack0 and Ack1 are never high in the same cycle.
- Requester contract:
  - Hold Req/We/Addr/WData stable until Ack.
  - Deassert Req, or present a new command, at the edge ending the Ack cycle.
  - Changes to We/Addr/WData while Req is pending and not yet granted are allowed; the values sampled in IDLE win.
- Fairness: under continuous requests from both sides, grants alternate strictly 0,1,0,1. The first tie after reset goes to requester 0.
- Reset mid-operation: the in-flight command is abandoned; no Ack/RValid is issued for it; RDataN is cleared to 0. Requesters must reissue after RST deasserts.
- Addresses wrap naturally within ADDR_WIDTH; no range checking.

Test Plan:
- Reset: RST=1 for 2 cycles with Req0=Req1=1 -> RF_WrEn=RF_RdEn=0, Ack*=0, RData*=0, Busy=0 throughout; first grant after release goes to requester 0.
- Single write then read: Req0 write Addr=2 WData=16'h0025 -> Ack0 1 cycle after sampling with RF_WrEn=1, RF_Address=2. Then Req0 read Addr=2 -> RF_RdEn 1 cycle after sampling; Ack0=RValid0=1 and RData0=16'h0025 three cycles after sampling.
- Contention: both request in the same cycle; Req0 writes Addr=5 16'h0194, Req1 reads Addr=5 -> requester 0 is served first; Req1 read returns 16'h0194 on RData1.
- Round-robin: both hold continuous reads (Addr0=1, Addr1=6) for 8 grants -> Ack order 0,1,0,1,0,1,0,1; never two Acks in one cycle; no request is served twice per ack.
- Reset mid-read: RST asserted in the CAPTURE cycle of a requester-1 read -> no Ack1/RValid1, RData1=0, state IDLE, RF enables 0 while RST=1.
- Held-request masking: requester holds Req0 one cycle past Ack0 on a read -> only one register-file access and one Ack0 for that command.
